// File: rtl/clk_div_gen.sv
// clk_div_gen: CH independent programmable clock dividers, each producing a
// registered divided clock, a one-cycle tick per period and a pending flag for
// a shadow ratio waiting to take effect. Ratio updates are applied only at a
// period boundary (or when the channel is idle or re-phased), so no runt
// pulses are produced.
//
// Optional build macro CLK_DIV_GEN_TICK_CNT_EN adds a per-channel tick_cnt
// output counting emitted ticks (modulo 2^CNT_W).
module clk_div_gen #(
    parameter int CH      = 2,
    parameter int CNT_W   = 16,
    parameter int DIV_RST = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  run,
    input  logic                  sync,
    input  logic                  load,
    input  logic [CH*CNT_W-1:0]   div_i,
    output logic [CH-1:0]         clk_out,
    output logic [CH-1:0]         tick,
    output logic [CH-1:0]         pend
`ifdef CLK_DIV_GEN_TICK_CNT_EN
    ,
    output logic [CH*CNT_W-1:0]   tick_cnt
`endif
);

    localparam logic [CNT_W-1:0] DIV_RST_W = CNT_W'(DIV_RST);
    localparam logic [CNT_W-1:0] ONE_W     = CNT_W'(1);

    // Per-channel state
    logic [CNT_W-1:0] cnt_q [CH];
    logic [CNT_W-1:0] cnt_d [CH];
    logic [CNT_W-1:0] div_q [CH];
    logic [CNT_W-1:0] div_d [CH];
    logic [CNT_W-1:0] shd_q [CH];
    logic [CNT_W-1:0] shd_d [CH];
    logic [CH-1:0]    pend_q, pend_d;
    logic [CH-1:0]    clk_out_q, clk_out_d;
    logic [CH-1:0]    tick_q, tick_d;

    // Intermediate per-channel terms
    logic [CNT_W-1:0] eff_cnt  [CH];
    logic [CNT_W:0]   high_cnt [CH];
    logic [CH-1:0]    last_eff;
    logic [CH-1:0]    wrap;
    logic [CH-1:0]    apply;

    // Next-state: counting, output generation and shadow-ratio handling
    always_comb begin
        for (int k = 0; k < CH; k++) begin
            // NOTE: every variable gets a default before any branch so no
            // path leaves it unassigned and no latch is inferred.
            cnt_d[k]     = '0;
            clk_out_d[k] = 1'b0;
            tick_d[k]    = 1'b0;

            // sync restarts the period from count zero on every channel
            eff_cnt[k]  = sync ? '0 : cnt_q[k];
            // High time is ceil(D/2); one extra bit keeps D=max from overflowing
            high_cnt[k] = ({1'b0, div_q[k]} + (CNT_W+1)'(1)) >> 1;
            last_eff[k] = (eff_cnt[k] == div_q[k] - ONE_W);
            wrap[k]     = (cnt_q[k] == div_q[k] - ONE_W);

            if (run && (div_q[k] != '0)) begin
                if (div_q[k] == ONE_W) begin
                    // Divide-by-one: output follows run, counter parked at 0
                    clk_out_d[k] = 1'b1;
                    tick_d[k]    = 1'b1;
                end else begin
                    tick_d[k]    = (eff_cnt[k] == '0);
                    clk_out_d[k] = ({1'b0, eff_cnt[k]} < high_cnt[k]);
                    cnt_d[k]     = last_eff[k] ? '0 : eff_cnt[k] + ONE_W;
                end
            end

            // A pending ratio takes over only where a period boundary is clean
            apply[k]  = pend_q[k] && (!run || (div_q[k] == '0) || sync || wrap[k]);
            div_d[k]  = apply[k] ? shd_q[k] : div_q[k];
            pend_d[k] = pend_q[k] && !apply[k];
            shd_d[k]  = shd_q[k];

            // A fresh load always lands in the shadow and re-arms pend,
            // even on the edge that applies the previous shadow value
            if (load) begin
                shd_d[k]  = div_i[k*CNT_W +: CNT_W];
                pend_d[k] = 1'b1;
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the per-channel arrays are a handful of control flops,
            // not a RAM, so they are reset explicitly like any other state.
            for (int k = 0; k < CH; k++) begin
                cnt_q[k] <= '0;
                div_q[k] <= DIV_RST_W;
                shd_q[k] <= DIV_RST_W;
            end
            pend_q    <= '0;
            clk_out_q <= '0;
            tick_q    <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge value of its inputs regardless of statement order.
            for (int k = 0; k < CH; k++) begin
                cnt_q[k] <= cnt_d[k];
                div_q[k] <= div_d[k];
                shd_q[k] <= shd_d[k];
            end
            pend_q    <= pend_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
        end
    end

    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign pend    = pend_q;

`ifdef CLK_DIV_GEN_TICK_CNT_EN
    logic [CNT_W-1:0] tcnt_q [CH];
    logic [CNT_W-1:0] tcnt_d [CH];

    // Tick counter: sync restarts it (counting its own tick), run=0 holds it
    always_comb begin
        for (int k = 0; k < CH; k++) begin
            tcnt_d[k] = tcnt_q[k];
            if (sync) begin
                tcnt_d[k] = tick_d[k] ? ONE_W : '0;
            end else if (tick_d[k]) begin
                tcnt_d[k] = tcnt_q[k] + ONE_W;
            end
        end
    end

    // Tick counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < CH; k++) tcnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < CH; k++) tcnt_q[k] <= tcnt_d[k];
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_tick_cnt
        assign tick_cnt[g*CNT_W +: CNT_W] = tcnt_q[g];
    end
`endif

endmodule

// File: tb/tb_clk_div_gen.sv
// tb_clk_div_gen: table of hand-derived vectors for the default-ratio start-up
// and first ratio change, then model-driven sequences (shadow overwrite, sync
// alignment, disable/divide-by-one, asynchronous reset). Expected outputs are
// queued at drive time and popped when the DUT result is sampled.
module tb_clk_div_gen;

    localparam int CH      = 2;
    localparam int CNT_W   = 16;
    localparam int DIV_RST = 2;

    logic                clk = 1'b0;
    logic                rst, run, sync, load;
    logic [CH*CNT_W-1:0] div_i;
    logic [CH-1:0]       clk_out, tick, pend;
`ifdef CLK_DIV_GEN_TICK_CNT_EN
    logic [CH*CNT_W-1:0] tick_cnt;
`endif

    always #5 clk = ~clk;

    clk_div_gen #(.CH(CH), .CNT_W(CNT_W), .DIV_RST(DIV_RST)) dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .sync    (sync),
        .load    (load),
        .div_i   (div_i),
        .clk_out (clk_out),
        .tick    (tick),
`ifdef CLK_DIV_GEN_TICK_CNT_EN
        .tick_cnt(tick_cnt),
`endif
        .pend    (pend)
    );

    typedef struct packed {
        logic [CH-1:0] clk;
        logic [CH-1:0] tick;
        logic [CH-1:0] pend;
    } exp_t;

    typedef struct {
        logic                run;
        logic                sync;
        logic                load;
        logic [CH*CNT_W-1:0] div;
        exp_t                exp;
    } vec_t;

    vec_t  tab [14];
    exp_t  exp_q [$];
    int    vectors     = 0;
    int    miscompares = 0;

    // Reference model state
    int m_cnt  [CH];
    int m_d    [CH];
    int m_s    [CH];
    bit m_pend [CH];

    task automatic check(input string name, input logic [3*CH-1:0] act,
                         input logic [3*CH-1:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s @%0t: got clk/tick/pend=%b want %b", name, $time, act, req);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < CH; k++) begin
            m_cnt[k]  = 0;
            m_d[k]    = DIV_RST;
            m_s[k]    = DIV_RST;
            m_pend[k] = 1'b0;
        end
    endfunction

    function automatic exp_t model_step(input logic r, input logic s,
                                        input logic l, input logic [CH*CNT_W-1:0] d);
        exp_t e;
        int   c, h, ncnt, nd;
        bit   ap, np;
        logic [CNT_W-1:0] slice;
        for (int k = 0; k < CH; k++) begin
            c    = s ? 0 : m_cnt[k];
            h    = (m_d[k] + 1) / 2;
            ncnt = 0;
            e.clk[k]  = 1'b0;
            e.tick[k] = 1'b0;
            if (r && m_d[k] == 1) begin
                e.clk[k]  = 1'b1;
                e.tick[k] = 1'b1;
            end else if (r && m_d[k] >= 2) begin
                e.tick[k] = (c == 0);
                e.clk[k]  = (c < h);
                ncnt      = (c == m_d[k] - 1) ? 0 : c + 1;
            end
            ap = m_pend[k] && (!r || m_d[k] == 0 || s || m_cnt[k] == m_d[k] - 1);
            nd = ap ? m_s[k] : m_d[k];
            np = m_pend[k] && !ap;
            if (l) begin
                slice  = d[k*CNT_W +: CNT_W];
                m_s[k] = int'(slice);
                np     = 1'b1;
            end
            m_cnt[k]  = ncnt;
            m_d[k]    = nd;
            m_pend[k] = np;
            e.pend[k] = np;
        end
        return e;
    endfunction

    // One clock: drive inputs, queue expectation, sample after the edge
    task automatic drive(input string name, input logic r, input logic s,
                         input logic l, input logic [CH*CNT_W-1:0] d,
                         input bit use_tab, input exp_t tab_exp);
        exp_t e, got;
        run   = r;
        sync  = s;
        load  = l;
        div_i = d;
        e = model_step(r, s, l, d);
        exp_q.push_back(use_tab ? tab_exp : e);
        @(posedge clk);
        #1;
        got = '{clk: clk_out, tick: tick, pend: pend};
        if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            check(name, got, exp_q.pop_front());
        end
    endtask

    task automatic step_m(input string name, input logic r, input logic s,
                          input logic l, input logic [CH*CNT_W-1:0] d);
        drive(name, r, s, l, d, 1'b0, '0);
    endtask

    task automatic idle(input string name, input int n);
        for (int i = 0; i < n; i++) step_m(name, 1'b1, 1'b0, 1'b0, div_i);
    endtask

    function automatic logic [CH*CNT_W-1:0] pack2(input int ch1, input int ch0);
        return {CNT_W'(ch1), CNT_W'(ch0)};
    endfunction

    initial begin
        // Default-ratio start-up, then load {ch1=5, ch0=4} mid-run
        //          run  sync load div          clk     tick    pend
        tab[0]  = '{1'b1, 1'b0, 1'b0, pack2(0,0), '{2'b11, 2'b11, 2'b00}};
        tab[1]  = '{1'b1, 1'b0, 1'b0, pack2(0,0), '{2'b00, 2'b00, 2'b00}};
        tab[2]  = '{1'b1, 1'b0, 1'b0, pack2(0,0), '{2'b11, 2'b11, 2'b00}};
        tab[3]  = '{1'b1, 1'b0, 1'b1, pack2(5,4), '{2'b00, 2'b00, 2'b11}};
        tab[4]  = '{1'b1, 1'b0, 1'b0, pack2(5,4), '{2'b11, 2'b11, 2'b11}};
        tab[5]  = '{1'b1, 1'b0, 1'b0, pack2(5,4), '{2'b00, 2'b00, 2'b00}};
        tab[6]  = '{1'b1, 1'b0, 1'b0, pack2(5,4), '{2'b11, 2'b11, 2'b00}};
        tab[7]  = '{1'b1, 1'b0, 1'b0, pack2(5,4), '{2'b11, 2'b00, 2'b00}};
        tab[8]  = '{1'b1, 1'b0, 1'b0, pack2(5,4), '{2'b10, 2'b00, 2'b00}};
        tab[9]  = '{1'b1, 1'b0, 1'b0, pack2(5,4), '{2'b00, 2'b00, 2'b00}};
        tab[10] = '{1'b1, 1'b0, 1'b0, pack2(5,4), '{2'b01, 2'b01, 2'b00}};
        tab[11] = '{1'b1, 1'b0, 1'b0, pack2(5,4), '{2'b11, 2'b10, 2'b00}};
        tab[12] = '{1'b0, 1'b0, 1'b0, pack2(5,4), '{2'b00, 2'b00, 2'b00}};
        tab[13] = '{1'b1, 1'b0, 1'b0, pack2(5,4), '{2'b11, 2'b11, 2'b00}};

        rst   = 1'b1;
        run   = 1'b0;
        sync  = 1'b0;
        load  = 1'b0;
        div_i = '0;
        model_reset();
        #12;
        check("reset_state", {clk_out, tick, pend}, '0);
        rst = 1'b0;

        for (int i = 0; i < 14; i++)
            drive($sformatf("tab[%0d]", i), tab[i].run, tab[i].sync, tab[i].load,
                  tab[i].div, 1'b1, tab[i].exp);

        // Shadow overwrite: D=7 running, load 3 then 10 before the wrap
        step_m("d7_load", 1'b1, 1'b0, 1'b1, pack2(7, 7));
        idle("d7_run", 10);
        step_m("load3", 1'b1, 1'b0, 1'b1, pack2(3, 3));
        idle("load3_run", 2);
        step_m("load10", 1'b1, 1'b0, 1'b1, pack2(10, 10));
        idle("d10_run", 25);

        // Sync alignment of D=3 (ch0) and D=4 (ch1)
        step_m("d34_load", 1'b1, 1'b0, 1'b1, pack2(4, 3));
        idle("d34_run", 13);
        step_m("sync", 1'b1, 1'b1, 1'b0, div_i);
        check("sync_aligned", {clk_out, tick}, 4'b1111);
        idle("post_sync", 25);

        // Disable ch0 with D=0, then divide-by-one applied at once
        step_m("d0_load", 1'b1, 1'b0, 1'b1, pack2(4, 0));
        idle("d0_run", 8);
        step_m("d1_load", 1'b1, 1'b0, 1'b1, pack2(4, 1));
        idle("d1_run", 5);
        check("d1_steady", {clk_out[0], tick[0], pend[0]}, 3'b110);

        // Asynchronous reset mid-period with D=9
        step_m("d9_load", 1'b1, 1'b0, 1'b1, pack2(9, 9));
        idle("d9_run", 12);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst", {clk_out, tick, pend}, '0);
        model_reset();
        @(posedge clk);
        #1;
        check("rst_held", {clk_out, tick, pend}, '0);
        rst = 1'b0;
        idle("post_rst", 6);
        step_m("sync_norun", 1'b0, 1'b1, 1'b0, div_i);
        idle("restart", 4);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
